// File: rtl/uart_pkg.sv
// Shared UART constants: default receive FIFO depth, the character-length
// encoding used by the receiver configuration, and the matching data mask.
package uart_pkg;

    localparam int DEFAULT_DEPTH = 8;

    localparam logic [3:0] LEN_5 = 4'd5;
    localparam logic [3:0] LEN_6 = 4'd6;
    localparam logic [3:0] LEN_7 = 4'd7;
    localparam logic [3:0] LEN_8 = 4'd8;

    // Bits above the configured length are cleared; unknown lengths pass through.
    function automatic logic [7:0] mask_char(input logic [3:0] len, input logic [7:0] data);
        case (len)
            LEN_5:   return {3'b000, data[4:0]};
            LEN_6:   return {2'b00, data[5:0]};
            LEN_7:   return {1'b0, data[6:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/uart_edge_detect.sv
// Rising-edge detector: one-cycle pulse when the level input goes high.
// RESET_VAL sets the assumed previous level coming out of reset.
module uart_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_q <= RESET_VAL;
        else        level_q <= level;
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: captures one masked character per
// rx_done rising edge, first-word fall-through read, sticky overflow flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 data_len,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_done,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [7:0]                 rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          wr_en;
    logic          pop;
    logic          drop;
    logic [CW-1:0] count_next;

    // Reset value 1: a level already high at reset release is not a new character.
    uart_edge_detect #(.RESET_VAL(1'b1)) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (rx_done),
        .pulse (push)
    );

    // A pop on the same cycle frees the slot, so a full FIFO can still accept.
    assign pop   = rd_en & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign drop  = push & full & ~rd_en;

    always_comb begin
        count_next = count;
        case ({wr_en, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= mask_char(data_len, rx_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CW'(DEPTH));
            // A new drop wins over a clear in the same cycle.
            if (drop)         overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
        end
    end

    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed stimulus, expected characters queued at
// push time and compared by a monitor whenever a pop is presented.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] data_len;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_len (data_len),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rd_en    (rd_en),
        .clr_err  (clr_err),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    endtask

    task automatic check_flags(input string tag, input logic [3:0] c, input logic e,
                               input logic f, input logic o);
        check({tag, "_count"}, {4'h0, count}, {4'h0, c});
        check({tag, "_empty"}, {7'h0, empty}, {7'h0, e});
        check({tag, "_full"}, {7'h0, full}, {7'h0, f});
        check({tag, "_overflow"}, {7'h0, overflow}, {7'h0, o});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // exp is the hand-computed stored value; stored=0 means the push must be dropped.
    task automatic push_char(input logic [3:0] len, input logic [7:0] d,
                             input logic [7:0] exp, input logic stored);
        data_len = len;
        rx_data  = d;
        rx_done  = 1'b1;
        if (stored) exp_q.push_back(exp);
        step();
        rx_done = 1'b0;
        step();
    endtask

    task automatic pop_char();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    // Monitor: every accepted pop is checked against the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL pop_unexpected: got %02h expected no data at %0t", rd_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pop_data", rd_data, mon_exp);
            end
        end
    end

    initial begin
        rst_n = 1'b0; data_len = LEN_8; rx_data = 8'h00;
        rx_done = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        step(); step();
        check_flags("reset", 4'd0, 1'b1, 1'b0, 1'b0);
        check("reset_rd_data", rd_data, 8'h00);
        rst_n = 1'b1;
        step();

        // Single character with rx_done held for four cycles.
        data_len = LEN_8; rx_data = 8'hAA; rx_done = 1'b1;
        exp_q.push_back(8'hAA);
        step();
        check("single_latency_rd", rd_data, 8'hAA);
        step(); step(); step();
        rx_done = 1'b0;
        step();
        check_flags("single", 4'd1, 1'b0, 1'b0, 1'b0);
        pop_char();
        check_flags("single_pop", 4'd0, 1'b1, 1'b0, 1'b0);

        // Masking by character length.
        push_char(LEN_5, 8'hFF, 8'h1F, 1'b1);
        check("mask5_rd", rd_data, 8'h1F);
        pop_char();
        push_char(LEN_7, 8'hFF, 8'h7F, 1'b1);
        pop_char();
        push_char(LEN_6, 8'hC3, 8'h03, 1'b1);
        pop_char();
        push_char(4'd4, 8'hA5, 8'hA5, 1'b1);
        pop_char();

        // Pop while empty is ignored.
        pop_char();
        check_flags("empty_pop", 4'd0, 1'b1, 1'b0, 1'b0);

        // Push and rd_en together while empty is a push only.
        data_len = LEN_8; rx_data = 8'h3C; rx_done = 1'b1; rd_en = 1'b1;
        exp_q.push_back(8'h3C);
        step();
        rx_done = 1'b0; rd_en = 1'b0;
        check_flags("empty_pushpop", 4'd1, 1'b0, 1'b0, 1'b0);
        check("empty_pushpop_rd", rd_data, 8'h3C);
        step();
        pop_char();

        // Fill then overflow on the ninth push.
        for (int i = 1; i <= 9; i++)
            push_char(LEN_8, 8'(i), 8'(i), i <= 8);
        check_flags("fill", 4'd8, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) pop_char();
        check_flags("drain", 4'd0, 1'b1, 1'b0, 1'b1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_err", {7'h0, overflow}, 8'h00);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 8; i++)
            push_char(LEN_8, 8'(8'h11 + i), 8'(8'h11 + i), 1'b1);
        data_len = LEN_8; rx_data = 8'h55; rx_done = 1'b1; rd_en = 1'b1;
        exp_q.push_back(8'h55);
        step();
        rx_done = 1'b0; rd_en = 1'b0;
        step();
        check_flags("full_pushpop", 4'd8, 1'b0, 1'b1, 1'b0);

        // Drop and clear in the same cycle leaves overflow set.
        data_len = LEN_8; rx_data = 8'h66; rx_done = 1'b1; clr_err = 1'b1;
        step();
        rx_done = 1'b0; clr_err = 1'b0;
        step();
        check_flags("drop_and_clr", 4'd8, 1'b0, 1'b1, 1'b1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_after_drop", {7'h0, overflow}, 8'h00);
        for (int i = 0; i < 8; i++) pop_char();
        check_flags("full_drain", 4'd0, 1'b1, 1'b0, 1'b0);

        // Wrap-around with interleaved push/pop pairs.
        for (int i = 0; i < 20; i++) begin
            push_char(LEN_8, 8'(8'h20 + 7 * i), 8'(8'h20 + 7 * i), 1'b1);
            check("wrap_count_push", {4'h0, count}, 8'd1);
            pop_char();
            check("wrap_count_pop", {4'h0, count}, 8'd0);
        end

        // Reset mid-operation with rx_done high.
        for (int i = 0; i < 3; i++)
            push_char(LEN_8, 8'(8'hC0 + i), 8'(8'hC0 + i), 1'b1);
        check("pre_reset_count", {4'h0, count}, 8'd3);
        rx_data = 8'h99; rx_done = 1'b1; rst_n = 1'b0;
        #1;
        check_flags("async_reset", 4'd0, 1'b1, 1'b0, 1'b0);
        check("async_reset_rd", rd_data, 8'h00);
        exp_q.delete();
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        check_flags("post_reset_high", 4'd0, 1'b1, 1'b0, 1'b0);
        rx_done = 1'b0;
        step();
        check("post_reset_fall", {4'h0, count}, 8'd0);
        rx_data = 8'h77; rx_done = 1'b1;
        exp_q.push_back(8'h77);
        step();
        rx_done = 1'b0;
        check_flags("post_reset_push", 4'd1, 1'b0, 1'b0, 1'b0);
        step();
        pop_char();
        step();

        total_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL leftover_expected: got %0d entries expected 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of stored characters (power of two, >=2).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port data_len, input, 4, receiver character length setting (same encoding as receiver config).
REQ-005 SHALL have port rx_data, input, 8, character from upstream receiver.
REQ-006 SHALL have port rx_done, input, 1, receiver completion flag; a level that may stay high for multiple cycles.
REQ-007 SHALL have port rd_en, input, 1, consumer pop request.
REQ-008 SHALL have port clr_err, input, 1, clears sticky overflow.
REQ-009 SHALL have port rd_data, output, 8, head character (first-word fall-through).
REQ-010 SHALL have port empty, output, 1, no characters stored.
REQ-011 SHALL have port full, output, 1, DEPTH characters stored.
REQ-012 SHALL have port count, output, log2(DEPTH)+1, characters stored.
REQ-013 SHALL have port overflow, output, 1, sticky flag: a character was dropped.

Function
REQ-014 SHALL generate push for exactly one cycle per rx_done rising edge: push = rx_done & ~rx_done_q, where rx_done_q is rx_done registered.
REQ-015 SHALL mask the stored character to data_len bits: for data_len 5..8, bits [7:data_len] stored as 0; other data_len values store all 8 bits unmodified.
REQ-016 SHALL write the masked character at wr_ptr on a push cycle when not full, or when full and rd_en=1 in the same cycle; wr_ptr then increments modulo DEPTH.
REQ-017 SHALL pop on rd_en=1 when not empty: rd_ptr increments modulo DEPTH, and rd_data shows the next character in the following cycle.
REQ-018 SHALL ignore rd_en when empty: no pointer change, no error flag.
REQ-019 SHALL handle push and pop in the same cycle with count unchanged, including when full; no overflow.
REQ-020 SHALL handle push and rd_en in the same cycle when empty as push only; the character appears on rd_data the next cycle with empty=0.
REQ-021 SHALL drop the character when pushing while full without a pop, leaving memory, pointers and count unchanged, and SHALL set overflow=1 in the next cycle.
REQ-022 SHALL clear overflow on clr_err=1; if clr_err and a new drop occur in the same cycle, overflow SHALL remain 1.
REQ-023 SHALL register count, empty and full, updating them in the cycle after a push or pop; empty=(count==0), full=(count==DEPTH).
REQ-024 SHALL drive rd_data = mem[rd_ptr] when not empty, and 8'h00 when empty.
REQ-025 SHALL wrap pointers from DEPTH-1 to 0 with no loss of data.
REQ-026 SHALL have a latency of one cycle from the rx_done rising edge to empty=0 and valid rd_data.

Reset
REQ-027 SHALL, while rst_n=0, immediately force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0 and rd_data=8'h00.
REQ-028 SHALL reset rx_done_q to 1, so that rx_done already high at reset release does not push a stale character.
REQ-029 SHALL discard all stored contents on reset mid-operation; the memory array is not reset.

Structure
REQ-030 SHALL take the default DEPTH and the data_len encoding constants from shared package uart_pkg.
REQ-031 SHALL contain one sub-module, uart_edge_detect, which produces the single-cycle push pulse and has a reset value parameter.

Verification
REQ-032 SHALL verify single character: data_len=8, rx_data=8'hAA, rx_done held high 4 cycles -> exactly one push, rd_data=8'hAA, count=1.
REQ-033 SHALL verify masking: data_len=5, rx_data=8'hFF -> stored 8'h1F.
REQ-034 SHALL verify fill and overflow: 9 pushes of 8'h01..8'h09 -> full=1, overflow=1, pops return 8'h01..8'h08; then clr_err -> overflow=0.
REQ-035 SHALL verify full with simultaneous push and pop: push 8'h55 plus rd_en while full -> count stays 8, overflow=0, 8'h55 returned last.
REQ-036 SHALL verify wrap-around: 20 interleaved push/pop pairs -> order preserved, count never exceeds 1.
REQ-037 SHALL verify reset mid-operation: rst_n low with 3 stored and rx_done high -> after release empty=1, count=0, and no push until rx_done falls and rises again.
